// File: rtl/tile_pkg.sv
// ---------------------------------------------------------------------------
// tile_pkg
// Shared definitions for the tilemap sequencer:
//   - default map geometry (tiles per row, rows per map, tile edge in pixels)
//   - bus widths (tile-map RAM address, tile index, pixel position)
//   - the sequencer FSM state encoding
//   - cnt_w(): counter width helper that never returns 0
// Optional build macro used by the sequencer: SKIP_EMPTY_TILE_EN.
// ---------------------------------------------------------------------------
package tile_pkg;

  localparam int MAP_W_DEF   = 20;
  localparam int MAP_H_DEF   = 15;
  localparam int TILE_PX_DEF = 8;

  localparam int ADDR_W = 9;  // tile-map RAM address width
  localparam int DATA_W = 8;  // tile index width
  localparam int POS_W  = 8;  // pixel coordinate width

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    WAIT_DATA  = 3'd2,
    ISSUE      = 3'd3,
    WAIT_START = 3'd4,
    WAIT_END   = 3'd5,
    ADVANCE    = 3'd6
  } state_t;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tilemap_sequencer_if.sv
// ---------------------------------------------------------------------------
// tilemap_sequencer_if
// Bundles the sequencer's control, tile-map RAM and tile-drawer signals.
//
// Signals:
//   start         : one-cycle frame request (to sequencer)
//   busy          : sequencer is not in IDLE
//   frame_done    : one-cycle pulse after the last tile of a frame completes
//   map_rd_addr   : tile-map RAM read address
//   map_rd_data   : tile index, valid one cycle after its address
//   tile_address  : tile index presented to the drawer
//   x_pos, y_pos  : tile top-left pixel presented to the drawer
//   draw          : one-cycle draw request
//   drawer_active : drawer is rendering a tile
//   state         : current sequencer FSM state (debug visibility)
//
// Drawer handshake: draw is a single-cycle request with tile_address/x_pos/
// y_pos valid in that cycle and held until the next request. The drawer
// acknowledges by raising drawer_active (in the draw cycle itself or any
// later cycle) and signals completion by dropping drawer_active; only then
// does the sequencer move to the next tile.
//
// Modports:
//   master : the sequencer side
//   slave  : the environment side (RAM, drawer, frame controller)
// ---------------------------------------------------------------------------
interface tilemap_sequencer_if;
  import tile_pkg::*;

  logic              start;
  logic              busy;
  logic              frame_done;
  logic [ADDR_W-1:0] map_rd_addr;
  logic [DATA_W-1:0] map_rd_data;
  logic [DATA_W-1:0] tile_address;
  logic [POS_W-1:0]  x_pos;
  logic [POS_W-1:0]  y_pos;
  logic              draw;
  logic              drawer_active;
  state_t            state;

  modport master (
    input  start,
    input  map_rd_data,
    input  drawer_active,
    output busy,
    output frame_done,
    output map_rd_addr,
    output tile_address,
    output x_pos,
    output y_pos,
    output draw,
    output state
  );

  modport slave (
    output start,
    output map_rd_data,
    output drawer_active,
    input  busy,
    input  frame_done,
    input  map_rd_addr,
    input  tile_address,
    input  x_pos,
    input  y_pos,
    input  draw,
    input  state
  );

endinterface

// File: rtl/tile_cursor.sv
// ---------------------------------------------------------------------------
// tile_cursor
// Walks the tile map in raster order. Holds column/row counters, the linear
// tile-map address (row*MAP_W+col) and the tile top-left pixel position
// (col*TILE_PX, row*TILE_PX). Every value is kept as a running counter so no
// multiplier is needed.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear_i    : return to tile (0,0)
//   advance_i  : step to the next tile; the last tile wraps to (0,0)
//   addr_o     : linear tile-map address of the current tile
//   x_o, y_o   : pixel position of the current tile
//   last_o     : current tile is the final tile of the map
// ---------------------------------------------------------------------------
module tile_cursor
  import tile_pkg::*;
#(
  parameter int MAP_W   = MAP_W_DEF,
  parameter int MAP_H   = MAP_H_DEF,
  parameter int TILE_PX = TILE_PX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [POS_W-1:0]  x_o,
  output logic [POS_W-1:0]  y_o,
  output logic              last_o
);

  localparam int COL_W = cnt_w(MAP_W);
  localparam int ROW_W = cnt_w(MAP_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAP_H - 1);
  localparam logic [POS_W-1:0] STEP     = POS_W'(TILE_PX);

  logic [COL_W-1:0]  col_q,  col_d;
  logic [ROW_W-1:0]  row_q,  row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [POS_W-1:0]  x_q,    x_d;
  logic [POS_W-1:0]  y_q,    y_d;
  logic              last;

  assign last = (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    x_d    = x_q;
    y_d    = y_q;
    if (clear_i || (advance_i && last)) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
      x_d    = '0;
      y_d    = '0;
    end else if (advance_i) begin
      // Raster order means the linear address simply counts up.
      addr_d = addr_q + 1'b1;
      if (col_q == COL_LAST) begin
        col_d = '0;
        x_d   = '0;
        row_d = row_q + 1'b1;
        y_d   = y_q + STEP;
      end else begin
        col_d = col_q + 1'b1;
        x_d   = x_q + STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign addr_o = addr_q;
  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = last;

endmodule

// File: rtl/tilemap_sequencer.sv
// ---------------------------------------------------------------------------
// tilemap_sequencer
// On a start request, walks every tile of an MAP_W x MAP_H tile map, reads
// its tile index from the tile-map RAM and hands index plus pixel position
// to a tile drawer, waiting for each tile to finish before moving on. A
// frame_done pulse follows the last tile.
//
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous active-high reset (wins over start)
//   bus   : tilemap_sequencer_if.master (start, busy, frame_done, tile-map
//           RAM read port, drawer request/handshake, debug state)
//
// Build option:
//   SKIP_EMPTY_TILE_EN : when defined, tiles whose index is 0 are skipped
//                        without a draw request. When undefined, index 0 is
//                        drawn like any other tile.
//
// Per-tile sequence: FETCH (address out) -> WAIT_DATA (RAM latency) ->
// ISSUE (draw) -> WAIT_START (drawer acknowledge) -> WAIT_END (drawer done)
// -> ADVANCE (next tile or end of frame).
// ---------------------------------------------------------------------------
module tilemap_sequencer
  import tile_pkg::*;
#(
  parameter int MAP_W   = MAP_W_DEF,
  parameter int MAP_H   = MAP_H_DEF,
  parameter int TILE_PX = TILE_PX_DEF
) (
  input  logic                clk,
  input  logic                reset,
  tilemap_sequencer_if.master bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tile_q,  tile_d;
  logic [POS_W-1:0]  x_q,     x_d;
  logic [POS_W-1:0]  y_q,     y_d;
  logic              ack_q,   ack_d;
  logic              done_q,  done_d;

  logic              cur_clear;
  logic              cur_adv;
  logic [ADDR_W-1:0] cur_addr;
  logic [POS_W-1:0]  cur_x;
  logic [POS_W-1:0]  cur_y;
  logic              cur_last;

  tile_cursor #(
    .MAP_W   (MAP_W),
    .MAP_H   (MAP_H),
    .TILE_PX (TILE_PX)
  ) u_cursor (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (cur_clear),
    .advance_i (cur_adv),
    .addr_o    (cur_addr),
    .x_o       (cur_x),
    .y_o       (cur_y),
    .last_o    (cur_last)
  );

  always_comb begin
    state_d   = state_q;
    tile_d    = tile_q;
    x_d       = x_q;
    y_d       = y_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    cur_clear = 1'b0;
    cur_adv   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cur_clear = 1'b1;
          state_d   = FETCH;
        end
      end

      // Address is already on map_rd_addr; the RAM samples it this cycle.
      FETCH: state_d = WAIT_DATA;

      WAIT_DATA: begin
`ifdef SKIP_EMPTY_TILE_EN
        if (bus.map_rd_data == '0) begin
          state_d = ADVANCE;
        end else begin
          tile_d  = bus.map_rd_data;
          x_d     = cur_x;
          y_d     = cur_y;
          state_d = ISSUE;
        end
`else
        tile_d  = bus.map_rd_data;
        x_d     = cur_x;
        y_d     = cur_y;
        state_d = ISSUE;
`endif
      end

      // A drawer that answers within the draw cycle itself is remembered
      // here, otherwise a one-cycle active pulse would be missed.
      ISSUE: begin
        ack_d   = bus.drawer_active;
        state_d = WAIT_START;
      end

      WAIT_START: begin
        if (bus.drawer_active || ack_q) begin
          ack_d   = 1'b0;
          state_d = WAIT_END;
        end
      end

      WAIT_END: begin
        if (!bus.drawer_active) begin
          state_d = ADVANCE;
        end
      end

      ADVANCE: begin
        cur_adv = 1'b1;
        if (cur_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tile_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  // Drawer outputs are registered copies so they stay put from one draw
  // request until the next, while the cursor has already moved on.
  assign bus.map_rd_addr  = cur_addr;
  assign bus.tile_address = tile_q;
  assign bus.x_pos        = x_q;
  assign bus.y_pos        = y_q;
  assign bus.draw         = (state_q == ISSUE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.frame_done   = done_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_tilemap_sequencer.sv
module tb_tilemap_sequencer;
  import tile_pkg::*;

  localparam int MAP_W   = 20;
  localparam int MAP_H   = 15;
  localparam int TILE_PX = 8;
  localparam int N_TILES = MAP_W * MAP_H;
  localparam int FRAME_LIMIT = 10000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tilemap_sequencer_if bus();

  tilemap_sequencer #(
    .MAP_W   (MAP_W),
    .MAP_H   (MAP_H),
    .TILE_PX (TILE_PX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- tile-map RAM model ----------------
  logic [7:0] mem [0:511];
  always @(posedge clk) bus.map_rd_data <= mem[bus.map_rd_addr];

  // ---------------- drawer model ----------------
  bit ack_in_issue = 1'b0;
  initial begin
    bus.drawer_active = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.draw) begin
        if (ack_in_issue) begin
          bus.drawer_active = 1'b1;
          @(negedge clk);
          bus.drawer_active = 1'b0;
        end else begin
          @(negedge clk);
          bus.drawer_active = 1'b1;
          repeat (4) @(negedge clk);
          bus.drawer_active = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  int draws_seen = 0;
  int fd_seen = 0;
  logic [7:0] last_x = 8'h00;
  logic [7:0] last_y = 8'h00;
  logic [7:0] tile_at_8_8 = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: raster order, tile t sits at col=t%MAP_W, row=t/MAP_W.
  function automatic int push_frame();
    int n = 0;
    for (int t = 0; t < N_TILES; t++) begin
      int col = t % MAP_W;
      int row = t / MAP_W;
`ifdef SKIP_EMPTY_TILE_EN
      if (mem[t] == 8'h00) continue;
`endif
      exp_q.push_back({mem[t], 8'(col * TILE_PX), 8'(row * TILE_PX)});
      n++;
    end
    return n;
  endfunction

  // Monitor: pops one expected tile per draw pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
      end else begin
        if (bus.draw || bus.frame_done)
          check("draw_and_frame_done", {31'd0, bus.draw & bus.frame_done}, 32'd0);
        if (bus.frame_done) fd_seen++;
        if (bus.draw) begin
          draws_seen++;
          last_x = bus.x_pos;
          last_y = bus.y_pos;
          if (bus.x_pos == 8'd8 && bus.y_pos == 8'd8) tile_at_8_8 = bus.tile_address;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_draw: got tile 0x%0h x %0d y %0d expected no draw at %0t",
                     bus.tile_address, bus.x_pos, bus.y_pos, $time);
          end else begin
            check("draw_tile", {8'd0, bus.tile_address, bus.x_pos, bus.y_pos}, {8'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle(input string tag);
    check({tag, "_draw"}, {31'd0, bus.draw}, 32'd0);
    check({tag, "_frame_done"}, {31'd0, bus.frame_done}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_addr"}, {23'd0, bus.map_rd_addr}, 32'd0);
    check({tag, "_tile"}, {24'd0, bus.tile_address}, 32'd0);
    check({tag, "_x"}, {24'd0, bus.x_pos}, 32'd0);
    check({tag, "_y"}, {24'd0, bus.y_pos}, 32'd0);
    check({tag, "_state"}, {29'd0, bus.state}, {29'd0, IDLE});
  endtask

  task automatic start_frame(output int d0, output int f0, output int n);
    int cnt = 0;
    bit got = 1'b0;
    n  = push_frame();
    d0 = draws_seen;
    f0 = fd_seen;
    @(negedge clk);
    bus.start = 1'b1;
    while (!got && cnt < 8) begin
      @(negedge clk);
      bus.start = 1'b0;
      cnt++;
      if (cnt == 1) begin
        check("fetch_addr_zero", {23'd0, bus.map_rd_addr}, 32'd0);
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
      end
      if (bus.draw) got = 1'b1;
    end
    check("first_draw_latency", cnt, 3);
  endtask

  task automatic finish_frame(input int d0, input int f0, input int n, input int mid_start_at);
    int guard = 0;
    bit pulsed = 1'b0;
    while (fd_seen == f0 && guard < FRAME_LIMIT) begin
      @(negedge clk);
      guard++;
      if (mid_start_at > 0 && !pulsed && (draws_seen - d0) >= mid_start_at) begin
        bus.start = 1'b1;
        pulsed = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("frame_done_in_time", {31'd0, guard < FRAME_LIMIT}, 32'd1);
    repeat (4) @(negedge clk);
    check("frame_done_count", fd_seen - f0, 1);
    check("draw_count", draws_seen - d0, n);
    check("queue_drained", exp_q.size(), 0);
    check("last_x", {24'd0, last_x}, 32'd152);
    check("last_y", {24'd0, last_y}, 32'd112);
    check("busy_after_frame", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic random_map();
    for (int t = 0; t < 512; t++)
      mem[t] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    mem[21]  = 8'h2A;
    mem[299] = 8'h11;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0, f0, n, guard;
    bus.start = 1'b0;
    random_map();
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    // Full frame, drawer busy 4 cycles per tile.
    ack_in_issue = 1'b0;
    start_frame(d0, f0, n);
    finish_frame(d0, f0, n, 0);
    check("tile_at_8_8", {24'd0, tile_at_8_8}, 32'h2A);

    // Drawer that answers only inside the draw cycle.
    random_map();
    ack_in_issue = 1'b1;
    start_frame(d0, f0, n);
    finish_frame(d0, f0, n, 0);
    ack_in_issue = 1'b0;

    // Start pulsed mid-frame must be ignored.
    random_map();
    start_frame(d0, f0, n);
    finish_frame(d0, f0, n, 100);

    // Reset while tile 57 waits for the drawer to finish, with start high.
    random_map();
    start_frame(d0, f0, n);
    guard = 0;
    while (!((draws_seen - d0) >= 58 && bus.state == WAIT_END) && guard < FRAME_LIMIT) begin
      @(negedge clk);
      guard++;
    end
    check("reached_tile_57", {31'd0, guard < FRAME_LIMIT}, 32'd1);
    check("reset_tile_count", draws_seen - d0, 58);
    reset = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    check_idle("mid_reset");
    bus.start = 1'b0;
    @(negedge clk);
    check_idle("reset_hold");
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check_idle("after_reset");
    start_frame(d0, f0, n);
    finish_frame(d0, f0, n, 0);

`ifdef SKIP_EMPTY_TILE_EN
    // Alternating empty/5 map: only the odd tiles are drawn.
    for (int t = 0; t < 512; t++) mem[t] = (t % 2 == 1) ? 8'h05 : 8'h00;
    start_frame(d0, f0, n);
    finish_frame(d0, f0, n, 0);
    check("skip_draw_count", draws_seen - d0, 150);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
